// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: controller states and default width.
package serial_add_ctrl_pkg;

  localparam int unsigned SerialAddDefaultWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } serial_add_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl_shift_reg.sv
// Parallel-load, right-shifting register with serial input at the MSB.
module serial_add_ctrl_shift_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             lsb
);

  logic [WIDTH-1:0] q_q, q_d, shifted;

  if (WIDTH == 1) begin : g_one
    assign shifted = ser_in;
  end else begin : g_many
    assign shifted = {ser_in, q_q[WIDTH-1:1]};
  end

  // Load takes priority so a new operand always wins over a stray shift.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (shift) begin
      q_d = shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q   = q_q;
  assign lsb = q_q[0];

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full_adder cell, LSB-first, WIDTH RUN cycles per op.
// Optional subtract mode (sub/ovf ports) when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SerialAddDefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  serial_add_state_e state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              carry_q, carry_d;
  logic              accept, run, last_bit;
  logic              sub_eff;
  logic [WIDTH-1:0]  b_load, sh_sum;
  logic              a_lsb, b_lsb, fa_sum, fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign accept   = in_valid && (state_q == StIdle);
  assign run      = (state_q == StRun);
  assign last_bit = (bit_cnt_q == LastBit);
  // Subtraction is a + ~b + 1, so the forced carry replaces cin.
  assign b_load   = sub_eff ? ~b : b;

  serial_add_ctrl_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (a),
    .shift     (run),
    .ser_in    (1'b0),
    .q         (),
    .lsb       (a_lsb)
  );

  serial_add_ctrl_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (b_load),
    .shift     (run),
    .ser_in    (1'b0),
    .q         (),
    .lsb       (b_lsb)
  );

  serial_add_ctrl_shift_reg #(.WIDTH(WIDTH)) u_sh_sum (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift     (run),
    .ser_in    (fa_sum),
    .q         (sh_sum),
    .lsb       ()
  );

  full_adder u_fa (
    .a    (a_lsb),
    .b    (b_lsb),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      carry_q   <= carry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    carry_d   = carry_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StRun;
          bit_cnt_d = '0;
          carry_d   = sub_eff ? 1'b1 : cin;
        end
      end
      StRun: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        carry_d   = fa_cout;
        if (last_bit) begin
          state_d   = StDone;
          bit_cnt_d = '0;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    sum       = out_valid ? sh_sum : '0;
    cout      = out_valid ? carry_q : 1'b0;
  end

`ifdef SERIAL_ADD_SUB_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (run && last_bit) begin
      ovf_q <= carry_q ^ fa_cout;
    end
  end

  assign ovf = out_valid ? ovf_q : 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: latency, arithmetic, backpressure, mid-op reset.
module tb_serial_add_ctrl;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          ovf;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;

  int unsigned   n_total = 0;
  int unsigned   n_pass  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

`ifndef SERIAL_ADD_SUB_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation, wait for the result, check it, then drain after ready_delay cycles.
  task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        input logic op_cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input int unsigned ready_delay, input bit check_lat);
    int unsigned lat;
    lat = 0;
    while (!in_ready && lat < 100) begin
      tick();
      lat++;
    end
    a = op_a;
    b = op_b;
    cin = op_cin;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom();
    b = $urandom();
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (check_lat) check({tag, " latency"}, lat, W);
    check({tag, " sum"}, {16'h0, sum}, {16'h0, exp_sum});
    check({tag, " cout"}, {31'h0, cout}, {31'h0, exp_cout});
    repeat (ready_delay) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (check_lat) check({tag, " idle after drain"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    logic [W-1:0] hold_sum;
    logic [W:0]   model;
    logic [W-1:0] ra, rb;
    logic         rc;

    #12;
    check("reset in_ready", {31'h0, in_ready}, 32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset sum", {16'h0, sum}, 32'h0);
    check("reset cout", {31'h0, cout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("3+5", 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 0, 1'b1);
    run_op("ffff+1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b1);
    run_op("7fff+0+c", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 2, 1'b1);
    run_op("ffff+ffff+c", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1, 1'b1);

    // Backpressure: result held in DONE, new operands ignored.
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp busy in run", {31'h0, busy}, 32'h1);
    repeat (W) tick();
    check("bp out_valid", {31'h0, out_valid}, 32'h1);
    check("bp sum", {16'h0, sum}, 32'h5555);
    hold_sum = sum;
    in_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'hAAAA;
    repeat (10) begin
      tick();
      check("bp sum stable", {16'h0, sum}, {16'h0, hold_sum});
      check("bp in_ready low", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp idle in_ready", {31'h0, in_ready}, 32'h1);
    check("bp idle out_valid", {31'h0, out_valid}, 32'h0);

    // Reset in the middle of RUN at bit 7.
    a = 16'hFFFF;
    b = 16'hFFFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("midrst in_ready", {31'h0, in_ready}, 32'h1);
    check("midrst out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst busy", {31'h0, busy}, 32'h0);
    check("midrst sum", {16'h0, sum}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post rst no stale", {31'h0, out_valid}, 32'h0);
    run_op("1234+1111", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 0, 1'b1);

    // Random operations with gaps on both sides.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      rc = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      repeat ($urandom_range(0, 3)) tick();
      run_op("rand", ra, rb, rc, model[W-1:0], model[W], $urandom_range(0, 3), 1'b0);
    end

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub 8000-1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1, 1'b1);
    sub = 1'b1;
    a = 16'h8000;
    b = 16'h0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    check("sub ovf set", {31'h0, ovf}, 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    a = 16'h0005;
    b = 16'h0005;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (W) tick();
    check("sub 5-5 sum", {16'h0, sum}, 32'h0);
    check("sub 5-5 cout", {31'h0, cout}, 32'h1);
    check("sub 5-5 ovf", {31'h0, ovf}, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    sub = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
